fetch_unit: RTL

Instruction fetch stage directly upstream of decode. It owns the PC and issues in-order read requests to instruction memory over a valid/ready request channel with a variable-latency, in-order response channel. Returned instructions are buffered and presented to decode as F_inst/F_pc with valid/ready. Branch/jump redirects from execute flush the buffer and discard in-flight responses.

---
 rtl/fetch_unit_pkg.sv | 13 +
 rtl/fetch_buf.sv | 78 +++++++
 rtl/fetch_unit.sv | 108 ++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared constants and helpers for the instruction fetch stage.
package fetch_unit_pkg;

  localparam int          XLEN_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int          INST_BYTES   = 4;

  // Bits needed to hold a count in the range 0..n.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// Synchronous FIFO used both as the {inst, pc} buffer and as the request-address tag queue.
// Flush has priority over push and pop; a push into a full FIFO is accepted only alongside a pop.
module fetch_buf
  import fetch_unit_pkg::*;
#(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 2,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    // NOTE: every *_d gets a default first so no path leaves it unassigned (no latch).
    do_push  = push && (!full || pop);
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses <= so all flops sample pre-edge values together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; an entry is only observed behind count, which is.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues in-order imem reads, buffers returned words for decode.
// Redirects flush the buffer and mark every in-flight request to be dropped on return.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int             XLEN      = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
  parameter int             MAX_OUT   = 2,
  parameter int             BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            F_valid,
  input  logic            D_ready,
  output logic [XLEN-1:0] F_inst,
  output logic [XLEN-1:0] F_pc
);

  localparam int OW = cnt_width(MAX_OUT);
  localparam int BW = cnt_width(BUF_DEPTH);
  localparam int SW = cnt_width(MAX_OUT + BUF_DEPTH);

  logic [XLEN-1:0]   pc_q, pc_d;
  logic [OW-1:0]     k_q, k_d;
  logic [OW-1:0]     outstanding;
  logic              tag_full, tag_empty;
  logic [XLEN-1:0]   tag_pc;
  logic [BW-1:0]     buf_count;
  logic              buf_full, buf_empty;
  logic [2*XLEN-1:0] buf_head;
  logic              accept, rsp_ok, rsp_keep, pop;
  logic [SW-1:0]     credit_used;

  // The tag queue depth tracks outstanding requests exactly, so its count is O.
  fetch_buf #(.WIDTH(XLEN), .DEPTH(MAX_OUT)) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (accept),
    .push_data (imem_req_addr),
    .pop       (rsp_ok),
    .flush     (1'b0),
    .pop_data  (tag_pc),
    .count     (outstanding),
    .full      (tag_full),
    .empty     (tag_empty)
  );

  fetch_buf #(.WIDTH(2 * XLEN), .DEPTH(BUF_DEPTH)) u_inst_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (rsp_keep),
    .push_data ({imem_rsp_data, tag_pc}),
    .pop       (pop),
    .flush     (redirect_valid),
    .pop_data  (buf_head),
    .count     (buf_count),
    .full      (buf_full),
    .empty     (buf_empty)
  );

  assign rsp_ok   = imem_rsp_valid && !tag_empty;
  assign rsp_keep = rsp_ok && (k_q == '0) && !redirect_valid;
  assign accept   = imem_req_valid && imem_req_ready;
  assign F_valid  = !buf_empty && !redirect_valid;
  assign pop      = F_valid && D_ready;
  assign F_inst   = buf_empty ? '0 : buf_head[2*XLEN-1:XLEN];
  assign F_pc     = buf_empty ? '0 : buf_head[XLEN-1:0];

  // Live in-flight requests plus buffered words must leave room for one more return.
  assign credit_used    = SW'(outstanding) - SW'(k_q) + SW'(buf_count) - SW'(pop);
  assign imem_req_valid = !rst && !redirect_valid && !tag_full && (credit_used < SW'(BUF_DEPTH));
  assign imem_req_addr  = pc_q;

  always_comb begin
    pc_d = pc_q;
    k_d  = k_q;
    if (redirect_valid) begin
      pc_d = redirect_pc;
      k_d  = outstanding - OW'(rsp_ok);
    end else begin
      if (accept) pc_d = pc_q + XLEN'(INST_BYTES);
      if (rsp_ok && (k_q != '0)) k_d = k_q - OW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
      k_q  <= '0;
    end else begin
      pc_q <= pc_d;
      k_q  <= k_d;
    end
  end

  a_no_orphan_rsp : assert property (@(posedge clk) disable iff (rst)
    !(imem_rsp_valid && tag_empty));
  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(rsp_keep && buf_full && !pop));

endmodule
